// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared mode encoding and select clamping for the mux_scan block.
// Optional feature macro used by this slice: MUX_SCAN_DWELL_EN.
package mux_scan_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Out-of-range manual selects fall onto the top channel, like the old
  // combinational mux's default branch.
  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned n_ch);
    return (sel >= n_ch) ? (n_ch - 1) : sel;
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: combinational rotate-priority finder. Returns the first
// enabled channel at or after ptr, wrapping around, plus a found flag.
module mux_scan_next #(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] ch_en,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  // cand[k] is the channel k positions after ptr; hit[k] says it is enabled.
  logic [CH_W-1:0] cand [N_CH];
  logic [N_CH-1:0] hit;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rot
      assign cand[gi] = CH_W'((32'(ptr) + 32'(gi)) % 32'(N_CH));
      assign hit[gi]  = ch_en[cand[gi]];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel W-bit mux with valid/ready output, manual
// select or round-robin auto scan over enabled channels.
// Define MUX_SCAN_DWELL_EN to add the dwell port and idle-gap counter.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int W       = 1,
`ifdef MUX_SCAN_DWELL_EN
  parameter  int DWELL_W = 8,
`endif
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [CH_W-1:0]   sel,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
`ifdef MUX_SCAN_DWELL_EN
  input  logic [DWELL_W-1:0] dwell,
`endif
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [W-1:0]    lanes [N_CH];
  logic [CH_W-1:0] sel_idx;
  logic            load;
  logic            found;
  logic [CH_W-1:0] next_idx;
  logic            gate_open;
  logic            auto_capture;

  logic [W-1:0]    out_data_reg, out_data_next;
  logic [CH_W-1:0] out_ch_reg, out_ch_next;
  logic            out_valid_reg, out_valid_next;
  logic [CH_W-1:0] ptr_reg, ptr_next;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign lanes[gi] = in_data[gi*W +: W];
    end
  endgenerate

  assign sel_idx = CH_W'(clamp_sel(32'(sel), N_CH));
  assign load    = !out_valid_reg || out_ready;

  mux_scan_next #(.N_CH(N_CH)) u_next (
    .ch_en (ch_en),
    .ptr   (ptr_reg),
    .found (found),
    .idx   (next_idx)
  );

`ifdef MUX_SCAN_DWELL_EN
  logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic               mode_reg;
  logic               mode_change;

  assign mode_change = (mode != mode_reg);
  // A fresh entry into auto mode starts with the gate open.
  assign gate_open   = (dwell_cnt_reg == '0) || mode_change;

  // Dwell counter: reload after an auto capture, clear on mode change,
  // otherwise count down in auto mode and hold in manual mode.
  always_comb begin
    dwell_cnt_next = dwell_cnt_reg;
    if (auto_capture) begin
      dwell_cnt_next = dwell;
    end else if (mode_change) begin
      dwell_cnt_next = '0;
    end else if (mode == MODE_AUTO && dwell_cnt_reg != '0) begin
      dwell_cnt_next = dwell_cnt_reg - 1'b1;
    end
  end

  // Dwell counter and previous-mode register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell_cnt_reg <= '0;
      mode_reg      <= MODE_MANUAL;
    end else begin
      dwell_cnt_reg <= dwell_cnt_next;
      mode_reg      <= mode;
    end
  end
`else
  assign gate_open = 1'b1;
`endif

  // Next output sample and scan pointer; state holds when there is no load.
  always_comb begin
    out_data_next  = out_data_reg;
    out_ch_next    = out_ch_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    auto_capture   = 1'b0;
    if (load) begin
      if (mode == MODE_MANUAL) begin
        out_data_next  = lanes[sel_idx];
        out_ch_next    = sel_idx;
        out_valid_next = 1'b1;
      end else if (gate_open && found) begin
        out_data_next  = lanes[next_idx];
        out_ch_next    = next_idx;
        out_valid_next = 1'b1;
        ptr_next       = (next_idx == CH_W'(N_CH - 1)) ? '0 : next_idx + 1'b1;
        auto_capture   = 1'b1;
      end else begin
        // Previous sample (if any) was accepted this edge; nothing replaces it.
        out_valid_next = 1'b0;
      end
    end
  end

  // Output register and scan pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed bench for mux_scan with a cycle-level reference model
// (4-channel, 8-bit instance) plus literal checks, and a 5-channel instance
// for select clamping. Honours MUX_SCAN_DWELL_EN.
module tb_mux_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        mode;
  logic [3:0]  ch_en;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
`ifdef MUX_SCAN_DWELL_EN
  logic [7:0]  dwell;
  logic [7:0]  dwell5;
`endif

  logic [39:0] in5;
  logic [2:0]  sel5;
  logic        mode5;
  logic [4:0]  ch_en5;
  logic        out_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_ch5;
  logic        out_valid5;

  mux_scan #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .ch_en     (ch_en),
`ifdef MUX_SCAN_DWELL_EN
    .dwell     (dwell),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_scan #(.N_CH(5), .W(8)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in5),
    .sel       (sel5),
    .mode      (mode5),
    .ch_en     (ch_en5),
`ifdef MUX_SCAN_DWELL_EN
    .dwell     (dwell5),
`endif
    .out_data  (out_data5),
    .out_ch    (out_ch5),
    .out_valid (out_valid5),
    .out_ready (out_ready5)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state (4-channel instance).
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;
  int         m_cnt;
  bit         m_prev_mode;
  bit         model_live = 1'b0;

  // Reference model: applies the block's rules once per rising edge.
  always @(posedge clk) begin : model
    bit can_load;
    bit changed;
    bit gate;
    bit took;
    int pick;
    int s;
    if (!rst_n) begin
      m_valid     = 1'b0;
      m_data      = 8'h00;
      m_ch        = 0;
      m_ptr       = 0;
      m_cnt       = 0;
      m_prev_mode = 1'b0;
    end else begin
      if (m_valid && out_ready)
        $display("txn accept ch=%0d data=%02h t=%0t", m_ch, m_data, $time);
      can_load = !m_valid || out_ready;
      changed  = (mode != m_prev_mode);
`ifdef MUX_SCAN_DWELL_EN
      gate = (m_cnt == 0) || changed;
`else
      gate = 1'b1;
`endif
      took = 1'b0;
      if (can_load) begin
        if (!mode) begin
          s       = (int'(sel) >= 4) ? 3 : int'(sel);
          m_data  = in_data[s*8 +: 8];
          m_ch    = s;
          m_valid = 1'b1;
        end else begin
          pick = -1;
          for (int k = 0; k < 4; k++)
            if (pick < 0 && ch_en[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
          if (gate && pick >= 0) begin
            m_data  = in_data[pick*8 +: 8];
            m_ch    = pick;
            m_valid = 1'b1;
            m_ptr   = (pick + 1) % 4;
            took    = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
      end
`ifdef MUX_SCAN_DWELL_EN
      if (took) m_cnt = int'(dwell);
      else if (changed) m_cnt = 0;
      else if (mode && m_cnt > 0) m_cnt = m_cnt - 1;
`endif
      m_prev_mode = mode;
    end
    model_live = 1'b1;
  end

  // Per-cycle comparison of the DUT against the model, on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("model_valid", 32'(out_valid), 32'(m_valid));
      check("model_data", 32'(out_data), 32'(m_data));
      check("model_ch", 32'(out_ch), 32'(m_ch));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 1, 3, 0, 1, 3};

    rst_n      = 1'b0;
    in_data    = 32'h44332211;
    sel        = 2'd2;
    mode       = 1'b0;
    ch_en      = 4'b0000;
    out_ready  = 1'b1;
    in5        = 40'h5544332211;
    sel5       = 3'd0;
    mode5      = 1'b0;
    ch_en5     = 5'b00000;
    out_ready5 = 1'b1;
`ifdef MUX_SCAN_DWELL_EN
    dwell  = 8'd0;
    dwell5 = 8'd0;
`endif

    // Reset state.
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ch", 32'(out_ch), 32'd0);

    // Manual select, one cycle after release.
    rst_n = 1'b1;
    step();
    check("man_sel2_data", 32'(out_data), 32'h33);
    check("man_sel2_ch", 32'(out_ch), 32'd2);
    sel = 2'd3;
    step();
    check("man_sel3_data", 32'(out_data), 32'h44);
    check("man_sel3_ch", 32'(out_ch), 32'd3);

    // Backpressure: output frozen while inputs churn.
    out_ready = 1'b0;
    sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      in_data = $urandom;
      step();
      check("bp_data", 32'(out_data), 32'h44);
      check("bp_ch", 32'(out_ch), 32'd3);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    in_data   = 32'hA0B0C0D0;
    out_ready = 1'b1;
    step();
    check("bp_release_data", 32'(out_data), 32'hC0);
    check("bp_release_ch", 32'(out_ch), 32'd1);

    // Auto scan skipping channel 2.
    mode  = 1'b1;
    ch_en = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step();
      check("scan_ch", 32'(out_ch), 32'(exp_seq[i]));
      check("scan_valid", 32'(out_valid), 32'd1);
    end

    // Empty mask: valid drops, pointer holds.
    ch_en = 4'b0000;
    step();
    check("empty_valid", 32'(out_valid), 32'd0);
    step();
    check("empty_valid2", 32'(out_valid), 32'd0);
    ch_en = 4'b0100;
    step();
    check("restore_valid", 32'(out_valid), 32'd1);
    check("restore_ch", 32'(out_ch), 32'd2);
    check("restore_data", 32'(out_data), 32'hB0);

`ifdef MUX_SCAN_DWELL_EN
    // Dwell: captures 4 cycles apart, cleared by mode switch.
    dwell = 8'd3;
    ch_en = 4'b1011;
    step();
    check("dwell_cap0_ch", 32'(out_ch), 32'd3);
    check("dwell_cap0_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("dwell_gap_valid", 32'(out_valid), 32'd0);
    end
    step();
    check("dwell_cap1_ch", 32'(out_ch), 32'd0);
    check("dwell_cap1_valid", 32'(out_valid), 32'd1);
    step();
    check("dwell_gap2_valid", 32'(out_valid), 32'd0);
    mode = 1'b0;
    sel  = 2'd1;
    step();
    check("dwell_man_ch", 32'(out_ch), 32'd1);
    mode = 1'b1;
    step();
    check("dwell_resume_valid", 32'(out_valid), 32'd1);
    check("dwell_resume_ch", 32'(out_ch), 32'd1);
    dwell = 8'd0;
    repeat (5) step();
`endif

    // Reset mid-scan restarts from channel 0.
    ch_en = 4'b1011;
    repeat (3) step();
    check("prerst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_ch", 32'(out_ch), 32'd0);
    rst_n = 1'b1;
    step();
    check("restart_ch", 32'(out_ch), 32'd0);
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_data", 32'(out_data), 32'hD0);

    // Clamp on the 5-channel instance.
    sel5 = 3'd4;
    step();
    check("n5_sel4_data", 32'(out_data5), 32'h55);
    check("n5_sel4_ch", 32'(out_ch5), 32'd4);
    sel5 = 3'd5;
    step();
    check("n5_sel5_ch", 32'(out_ch5), 32'd4);
    sel5 = 3'd7;
    step();
    check("n5_sel7_data", 32'(out_data5), 32'h55);
    check("n5_sel7_ch", 32'(out_ch5), 32'd4);
    sel5 = 3'd2;
    step();
    check("n5_sel2_data", 32'(out_data5), 32'h33);
    check("n5_sel2_ch", 32'(out_ch5), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
